// File: rtl/vx_gbar_unit.sv
// Cluster-level global barrier unit. It tracks per-barrier arrival masks
// and broadcasts a one-cycle release when the last participant arrives.
module vx_gbar_unit #(
    parameter int NUM_BARRIERS = 8,
    parameter int NUM_CORES    = 4,
    localparam int ID_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
    localparam int CW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [ID_W-1:0] req_id,
    input  logic [CW-1:0]   req_size_m1,
    input  logic [CW-1:0]   req_core_id,
    output logic            req_ready,
    output logic            rsp_valid,
    output logic [ID_W-1:0] rsp_id,
    output logic            busy,
    output logic            err,
    output logic [31:0]     perf_releases
);

    logic [NUM_CORES-1:0]    mask_q [NUM_BARRIERS];
    logic [CW:0]             cnt_q  [NUM_BARRIERS];
    logic [CW-1:0]           size_q [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] active_q;

    logic                    id_ok;
    logic                    core_ok;
    logic                    in_range;
    logic                    accept;
    logic [NUM_CORES-1:0]    cur_mask;
    logic [CW:0]             cur_cnt;
    logic [CW-1:0]           cur_size;
    logic                    cur_active;
    logic [CW-1:0]           eff_size;
    logic                    dup;
    logic                    mism;
    logic                    upd;
    logic                    fire;
    logic                    err_set;
    logic [NUM_BARRIERS-1:0] active_nxt;

    // Index range checks only matter for non-power-of-two configurations.
    if (NUM_BARRIERS == (1 << ID_W)) begin : g_id_full
        assign id_ok = 1'b1;
    end else begin : g_id_chk
        assign id_ok = (req_id < ID_W'(NUM_BARRIERS));
    end

    if (NUM_CORES == (1 << CW)) begin : g_core_full
        assign core_ok = 1'b1;
    end else begin : g_core_chk
        assign core_ok = (req_core_id < CW'(NUM_CORES));
    end

    assign req_ready = ~reset;

    always_comb begin
        in_range   = id_ok && core_ok;
        accept     = req_valid && !reset;
        cur_mask   = '0;
        cur_cnt    = '0;
        cur_size   = '0;
        cur_active = 1'b0;
        if (in_range) begin
            cur_mask   = mask_q[req_id];
            cur_cnt    = cnt_q[req_id];
            cur_size   = size_q[req_id];
            cur_active = active_q[req_id];
        end
        eff_size = cur_active ? cur_size : req_size_m1;
        dup      = in_range && cur_mask[req_core_id];
        mism     = in_range && cur_active && (req_size_m1 != cur_size);
        upd      = accept && in_range && !dup;
        fire     = upd && (cur_cnt == {1'b0, eff_size});
        err_set  = accept && (!in_range || dup || mism);
        active_nxt = active_q;
        if (upd) begin
            active_nxt[req_id] = !fire;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                mask_q[b] <= '0;
                cnt_q[b]  <= '0;
                size_q[b] <= '0;
            end
            active_q      <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            busy          <= 1'b0;
            err           <= 1'b0;
            perf_releases <= '0;
        end else begin
            active_q      <= active_nxt;
            rsp_valid     <= fire;
            busy          <= |active_nxt;
            err           <= err | err_set;
            perf_releases <= perf_releases + 32'(fire);
            if (fire) begin
                rsp_id <= req_id;
            end
            if (upd) begin
                if (fire) begin
                    mask_q[req_id] <= '0;
                    cnt_q[req_id]  <= '0;
                end else begin
                    mask_q[req_id][req_core_id] <= 1'b1;
                    cnt_q[req_id] <= cur_cnt + (CW+1)'(1);
                    if (!cur_active) begin
                        size_q[req_id] <= req_size_m1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vx_gbar_unit.sv
// Bench for vx_gbar_unit: directed scenarios plus random traffic,
// scored against a set-based barrier model.
module tb_vx_gbar_unit;

    localparam int NB = 8;
    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_id = '0;
    logic [1:0]  req_size_m1 = '0;
    logic [1:0]  req_core_id = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [2:0]  rsp_id;
    logic        busy;
    logic        err;
    logic [31:0] perf_releases;

    vx_gbar_unit #(
        .NUM_BARRIERS(NB),
        .NUM_CORES(NC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_id(req_id),
        .req_size_m1(req_size_m1),
        .req_core_id(req_core_id),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .busy(busy),
        .err(err),
        .perf_releases(perf_releases)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: each barrier is a set of arrived cores plus the size latched
    // by the first arrival of the current epoch.
    bit          seen [NB][NC];
    int          lsize [NB];
    bit          m_err = 1'b0;
    int unsigned m_perf = 0;
    bit          m_rst = 1'b1;
    int          exp_q [$];
    int          pref [NB];

    function automatic int arrivals(int b);
        int k = 0;
        for (int c = 0; c < NC; c++) k += int'(seen[b][c]);
        return k;
    endfunction

    function automatic bit m_busy();
        for (int b = 0; b < NB; b++)
            if (arrivals(b) > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int b = 0; b < NB; b++) begin
            lsize[b] = 0;
            for (int c = 0; c < NC; c++) seen[b][c] = 1'b0;
        end
        m_err  = 1'b0;
        m_perf = 0;
    endtask

    task automatic m_issue(int b, int s, int c);
        int k;
        int eff;
        k = arrivals(b);
        if (seen[b][c]) begin
            m_err = 1'b1;
            return;
        end
        if (k > 0 && s != lsize[b]) m_err = 1'b1;
        eff = (k > 0) ? lsize[b] : s;
        if (k + 1 == eff + 1) begin
            for (int i = 0; i < NC; i++) seen[b][i] = 1'b0;
            exp_q.push_back(b);
            m_perf++;
        end else begin
            if (k == 0) lsize[b] = s;
            seen[b][c] = 1'b1;
        end
    endtask

    task automatic step(input bit rst, input bit v, input int b,
                        input int s, input int c);
        @(negedge clk);
        reset       = rst;
        req_valid   = v;
        req_id      = 3'(b);
        req_size_m1 = 2'(s);
        req_core_id = 2'(c);
        m_rst       = rst;
        if (rst) m_reset();
        else if (v) m_issue(b, s, c);
    endtask

    task automatic arrive(input int b, input int s, input int c);
        step(1'b0, 1'b1, b, s, c);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: samples just after each rising edge.
    initial begin
        int e;
        forever begin
            @(posedge clk);
            #1;
            chk("req_ready", 32'(req_ready), 32'(!m_rst));
            chk("busy", 32'(busy), 32'(m_busy()));
            chk("err", 32'(err), 32'(m_err));
            chk("perf_releases", perf_releases, m_perf);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_spurious: got id %0d expected none at %0t",
                             rsp_id, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e));
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_missing: got rsp_valid %b expected id %0d at %0t",
                         rsp_valid, e, $time);
            end
        end
    end

    initial begin
        m_reset();
        do_reset();
        do_reset();

        for (int c = 0; c < 4; c++) arrive(3, 3, c);
        idle();
        arrive(5, 0, 1);
        idle();

        arrive(1, 1, 2);
        arrive(1, 1, 2);
        idle();
        arrive(1, 1, 0);
        idle();
        do_reset();

        arrive(0, 1, 0);
        arrive(7, 1, 0);
        arrive(0, 1, 1);
        arrive(7, 1, 1);
        idle();

        for (int c = 0; c < 3; c++) arrive(2, 3, c);
        do_reset();
        arrive(2, 3, 3);
        idle();
        arrive(2, 3, 0);
        arrive(2, 3, 1);
        arrive(2, 3, 2);
        idle();
        do_reset();

        arrive(4, 1, 0);
        arrive(4, 2, 1);
        idle();
        do_reset();

        for (int b = 0; b < NB; b++) pref[b] = $urandom_range(0, 3);
        for (int i = 0; i < 3000; i++) begin
            int r;
            int b;
            int s;
            r = $urandom_range(0, 99);
            b = $urandom_range(0, NB - 1);
            s = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : pref[b];
            if (r < 2) begin
                do_reset();
            end else if (r < 15) begin
                idle();
            end else begin
                arrive(b, s, $urandom_range(0, NC - 1));
            end
        end

        idle();
        idle();
        idle();
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
